// File: rtl/uart_rx_word_if.sv
// uart_rx_word_if: word read handshake between the UART receiver FIFO and the IO buffer
//   rx_word        FIFO head word, meaningful while rx_word_valid is high
//   rx_word_valid  FIFO not empty
//   rx_word_ready  pop request from the consumer
//   rx_full        FIFO holds its maximum number of words
interface uart_rx_word_if;
   logic [31:0] rx_word;
   logic        rx_word_valid;
   logic        rx_word_ready;
   logic        rx_full;
   modport master (output rx_word, rx_word_valid, rx_full, input rx_word_ready);
   modport slave  (input rx_word, rx_word_valid, rx_full, output rx_word_ready);
endinterface

// File: rtl/uart_rx_word.sv
// uart_rx_word: UART receiver packing 8N1 bytes little-endian into 32-bit words queued in a FIFO
//   CLK, RST     clock and synchronous active-high reset
//   rxd          asynchronous serial input, idle high
//   rx_if        word FIFO read side (rx_word, rx_word_valid, rx_word_ready, rx_full)
//   overrun_err  sticky: completed word dropped on a full FIFO
//   frame_err    sticky: stop bit sampled low
//   parity_err   sticky: even-parity mismatch (only with UART_RX_PARITY_EN, frame becomes 8E1)
//   err_clear    clears the sticky flags; a same-cycle set event wins
module uart_rx_word #(
   parameter int CLK_PER_BIT = 868,
   parameter int FIFO_AW     = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            rxd,
   uart_rx_word_if.master  rx_if,
   output logic            overrun_err,
   output logic            frame_err,
`ifdef UART_RX_PARITY_EN
   output logic            parity_err,
`endif
   input  logic            err_clear
);
   localparam int CW    = $clog2(CLK_PER_BIT);
   localparam int PW    = FIFO_AW + 1;
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;
   state_t          r_state, w_state;
   logic [1:0]      r_sync;
   logic [CW-1:0]   r_cnt, w_cnt;
   logic [2:0]      r_idx, w_idx;
   logic [7:0]      r_shift, w_shift;
   logic            r_pbad, w_pbad;
   logic            w_accept, w_ferr, w_perr;
   logic [1:0]      r_bcnt;
   logic [23:0]     r_part;
   logic [31:0]     r_mem [DEPTH];
   logic [PW-1:0]   r_wp, r_rp;
   logic            r_ovr, r_ferr, r_perr;
   logic            w_rx, w_tick, w_empty, w_full, w_pop, w_push_req, w_push;
   assign w_rx       = r_sync[1];
   assign w_tick     = r_cnt == '0;
   assign w_empty    = r_wp == r_rp;
   assign w_full     = (r_wp[FIFO_AW] != r_rp[FIFO_AW]) && (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]);
   assign w_pop      = !w_empty && rx_if.rx_word_ready;
   assign w_push_req = w_accept && r_bcnt == 2'd3;
   // a pop in the same cycle frees the slot the new word needs
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign rx_if.rx_word       = r_mem[r_rp[FIFO_AW-1:0]];
   assign rx_if.rx_word_valid = !w_empty;
   assign rx_if.rx_full       = w_full;
   assign overrun_err = r_ovr;
   assign frame_err   = r_ferr;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = r_perr;
`endif
   always_comb begin
      w_state  = r_state;
      w_cnt    = w_tick ? r_cnt : r_cnt - CW'(1);
      w_idx    = r_idx;
      w_shift  = r_shift;
      w_pbad   = r_pbad;
      w_accept = 1'b0;
      w_ferr   = 1'b0;
      w_perr   = 1'b0;
      case (r_state)
         S_IDLE: if (!w_rx) begin
            w_state = S_START;
            w_cnt   = HALF;
         end
         S_START: if (w_tick) begin
            w_state = w_rx ? S_IDLE : S_DATA;
            w_cnt   = FULL;
            w_idx   = 3'd0;
            w_pbad  = 1'b0;
         end
         S_DATA: if (w_tick) begin
            w_shift = {w_rx, r_shift[7:1]};
            w_idx   = r_idx + 3'd1;
            w_cnt   = FULL;
`ifdef UART_RX_PARITY_EN
            w_state = r_idx == 3'd7 ? S_PARITY : S_DATA;
`else
            w_state = r_idx == 3'd7 ? S_STOP : S_DATA;
`endif
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (w_tick) begin
            w_perr  = w_rx != ^r_shift;
            w_pbad  = w_perr;
            w_cnt   = FULL;
            w_state = S_STOP;
         end
`endif
         S_STOP: if (w_tick) begin
            w_accept = w_rx && !r_pbad;
            w_ferr   = !w_rx;
            w_state  = w_rx ? S_IDLE : S_WAIT_HIGH;
         end
         S_WAIT_HIGH: w_state = w_rx ? S_IDLE : S_WAIT_HIGH;
         default: w_state = S_IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_sync  <= 2'b11;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_pbad  <= 1'b0;
         r_bcnt  <= '0;
         r_part  <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_ovr   <= 1'b0;
         r_ferr  <= 1'b0;
         r_perr  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_state <= w_state;
         r_sync  <= {r_sync[0], rxd};
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_shift <= w_shift;
         r_pbad  <= w_pbad;
         r_ovr   <= (w_push_req && !w_push) || (r_ovr && !err_clear);
         r_ferr  <= w_ferr || (r_ferr && !err_clear);
         r_perr  <= w_perr || (r_perr && !err_clear);
         if (w_accept) begin
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt != 2'd3) r_part[{r_bcnt, 3'b000} +: 8] <= w_shift;
         end
         if (w_push) begin
            r_mem[r_wp[FIFO_AW-1:0]] <= {w_shift, r_part};
            r_wp <= r_wp + PW'(1);
         end
         if (w_pop) r_rp <= r_rp + PW'(1);
      end
   end
endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed self-checking bench for uart_rx_word with CLK_PER_BIT=16, FIFO_AW=2
module tb_uart_rx_word;
   localparam int CPB = 16;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic rxd = 1'b1;
   logic err_clear = 1'b0;
   logic overrun_err, frame_err;
`ifdef UART_RX_PARITY_EN
   logic parity_err;
`endif
   int n_vec = 0;
   int n_err = 0;
   uart_rx_word_if rx_if ();
   always #5 CLK = ~CLK;
   uart_rx_word #(.CLK_PER_BIT(CPB), .FIFO_AW(2)) dut (
      .CLK(CLK),
      .RST(RST),
      .rxd(rxd),
      .rx_if(rx_if),
      .overrun_err(overrun_err),
      .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err(parity_err),
`endif
      .err_clear(err_clear)
   );
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic send_bits(input logic [7:0] b);
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rxd = ^b;
      tick(CPB);
`endif
   endtask
   task automatic send_byte(input logic [7:0] b);
      send_bits(b);
      rxd = 1'b1;
      tick(CPB);
   endtask
   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask
   task automatic pop();
      rx_if.rx_word_ready = 1'b1;
      tick(1);
      rx_if.rx_word_ready = 1'b0;
   endtask
   task automatic clear_err();
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
   endtask
   initial begin
      rx_if.rx_word_ready = 1'b0;
      tick(3);
      chk("rst_valid", 32'(rx_if.rx_word_valid), 0);
      chk("rst_full", 32'(rx_if.rx_full), 0);
      chk("rst_ovr", 32'(overrun_err), 0);
      chk("rst_ferr", 32'(frame_err), 0);
      chk("rst_word", rx_if.rx_word, 0);
      RST = 1'b0;
      tick(5);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_bits(8'h12);
      rxd = 1'b1;
      tick(10);
      chk("lat_before", 32'(rx_if.rx_word_valid), 0);
      tick(1);
      chk("lat_after", 32'(rx_if.rx_word_valid), 1);
      chk("word1", rx_if.rx_word, 32'h12345678);
      tick(5);
      pop();
      chk("pop_empty", 32'(rx_if.rx_word_valid), 0);
      for (int i = 0; i < 5; i++) begin
         send_word(32'hA0B0C0D0 + 32'(i));
         if (i == 3) begin
            chk("full_at4", 32'(rx_if.rx_full), 1);
            chk("no_ovr_at4", 32'(overrun_err), 0);
         end
      end
      chk("ovr_at5", 32'(overrun_err), 1);
      chk("full_at5", 32'(rx_if.rx_full), 1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("order%0d", i), rx_if.rx_word, 32'hA0B0C0D0 + 32'(i));
         pop();
      end
      chk("drained", 32'(rx_if.rx_word_valid), 0);
      chk("ovr_sticky", 32'(overrun_err), 1);
      clear_err();
      chk("ovr_clear", 32'(overrun_err), 0);
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      tick(40);
      chk("glitch_valid", 32'(rx_if.rx_word_valid), 0);
      send_word(32'hCAFEBABE);
      chk("glitch_word", rx_if.rx_word, 32'hCAFEBABE);
      pop();
      send_bits(8'hA5);
      rxd = 1'b0;
      tick(3 * CPB);
      chk("ferr_set", 32'(frame_err), 1);
      chk("ferr_novalid", 32'(rx_if.rx_word_valid), 0);
      rxd = 1'b1;
      tick(CPB);
      send_word(32'h04030201);
      chk("ferr_word", rx_if.rx_word, 32'h04030201);
      pop();
      chk("ferr_sticky", 32'(frame_err), 1);
      clear_err();
      chk("ferr_clear", 32'(frame_err), 0);
      for (int i = 0; i < 4; i++) send_word(32'h55500000 + 32'(i));
      send_byte(8'h04);
      send_byte(8'h00);
      send_byte(8'h50);
      send_bits(8'h55);
      rxd = 1'b1;
      tick(10);
      rx_if.rx_word_ready = 1'b1;
      tick(1);
      rx_if.rx_word_ready = 1'b0;
      tick(5);
      chk("pp_no_ovr", 32'(overrun_err), 0);
      chk("pp_full", 32'(rx_if.rx_full), 1);
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("pp_order%0d", i), rx_if.rx_word, 32'h55500000 + 32'(i));
         pop();
      end
      chk("pp_drained", 32'(rx_if.rx_word_valid), 0);
      send_word(32'h600D600D);
      send_bits(8'hEE);
      rxd = 1'b0;
      tick(CPB);
      rxd = 1'b1;
      tick(CPB);
      send_byte(8'hAA);
      send_byte(8'hBB);
      chk("pre_rst_valid", 32'(rx_if.rx_word_valid), 1);
      chk("pre_rst_ferr", 32'(frame_err), 1);
      RST = 1'b1;
      tick(1);
      chk("mid_rst_valid", 32'(rx_if.rx_word_valid), 0);
      chk("mid_rst_full", 32'(rx_if.rx_full), 0);
      chk("mid_rst_ovr", 32'(overrun_err), 0);
      chk("mid_rst_ferr", 32'(frame_err), 0);
      chk("mid_rst_word", rx_if.rx_word, 0);
      RST = 1'b0;
      tick(2);
      send_word(32'h44332211);
      chk("post_rst_valid", 32'(rx_if.rx_word_valid), 1);
      chk("post_rst_word", rx_if.rx_word, 32'h44332211);
      pop();
      chk("post_rst_drained", 32'(rx_if.rx_word_valid), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- UART receiver that turns the serial RX line into 32-bit words for the IO buffer's read path (s_chkRx/s_read).
- Samples 8N1 frames, packs 4 bytes little-endian into one word, and queues words in a small FIFO.
- The IO buffer checks `rx_word_valid`, takes `rx_word`, and pops with `rx_word_ready`.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW words.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial RX line; idle high.
- rx_word  output  32  FIFO head word; valid only while `rx_word_valid`=1.
- rx_word_valid  output  1  FIFO not empty.
- rx_word_ready  input  1  pop request; pops when `rx_word_valid`&&`rx_word_ready`.
- rx_full  output  1  FIFO holds 2**FIFO_AW words.
- overrun_err  output  1  sticky: a completed word was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.
- err_clear  input  1  clears all sticky error flags.

Behaviour:
- Reset (RST=1 at a clock edge):
  - Flags and status: `rx_word_valid`=0, `rx_full`=0, `overrun_err`=0, `frame_err`=0, `rx_word`=0.
  - Storage: FIFO emptied, byte packer count=0.
  - Synchronizer flops preset to 1; FSM to IDLE.
  - Reset mid-frame abandons the frame and any partial word.
- Input sync: `rxd` passes through 2 flops before use. All timing below refers to the synchronized signal.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: synced rxd==0 → START, bit counter loaded with CLK_PER_BIT/2-1.
  - START: at counter==0, resample. If 1, treat as glitch → IDLE. If 0 → DATA, counter=CLK_PER_BIT-1, bit index=0.
  - DATA: sample at each counter==0 (mid-bit), shift in LSB first. After bit 7 → STOP, counter=CLK_PER_BIT-1.
  - STOP: at counter==0, sample.
    - 1: byte accepted → IDLE.
    - 0: `frame_err` set, byte discarded → WAIT_HIGH.
  - WAIT_HIGH: stay until synced rxd==1 → IDLE. This prevents a break condition from starting a new frame.
- Byte packer:
  - Accepted byte n (n=0..3) goes into word bits [8n+7:8n]; count increments.
  - On the 4th byte, the assembled word is pushed the same cycle and count returns to 0.
  - Discarded bytes do not advance count.
- FIFO:
  - Push when the 4th byte is accepted and (not full, or a pop occurs in the same cycle).
  - If full with no simultaneous pop: word dropped, `overrun_err` set, FIFO contents unchanged.
  - Pop when `rx_word_valid`&&`rx_word_ready`; pop on empty is ignored.
  - Simultaneous push/pop on empty: FIFO ends with 1 word. Empty-state push is not bypassed to `rx_word` combinationally.
  - `rx_word` is driven from the registered head (read data from the register array at the read pointer).
- Latency: `rx_word_valid` rises the cycle after the stop-bit sample of the 4th byte.
- Pointers: FIFO_AW+1 bits; wrap naturally.
  - full: MSBs differ and low bits equal.
  - empty: pointers equal.
- Sticky flags: `err_clear` clears them. If a set event and `err_clear` occur in the same cycle, set wins.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit follows bit 7 (extra state PARITY, sampled mid-bit).
  - Extra port `parity_err` (output, 1 bit, sticky, reset 0, cleared by `err_clear`, set wins).
  - Parity mismatch sets `parity_err` and discards the byte; the packer does not advance. The stop bit is still checked.
- Undefined: 8N1 only; no PARITY state and no `parity_err` port.

Test Plan:
- CLK_PER_BIT=16, FIFO_AW=2; send bytes 0x78,0x56,0x34,0x12 → `rx_word_valid` rises 1 cycle after the 4th stop-bit sample; `rx_word`=0x12345678; pulse `rx_word_ready` → `rx_word_valid`=0.
- Send 5 words (20 bytes) without popping → `rx_full`=1 after word 4; word 5 dropped, `overrun_err`=1. Pops return words 1..4 in order; `err_clear` → `overrun_err`=0.
- Low glitch on rxd of 4 cycles (< CLK_PER_BIT/2) → FSM returns to IDLE, no byte accepted, packer count unchanged.
- Byte 0xA5 with stop bit held low for 3 bit times → `frame_err`=1; no new frame until rxd high. Next 4 good bytes 0x01..0x04 → word 0x04030201.
- With FIFO full, pop in the same cycle the 4th byte completes → no overrun; FIFO stays full; new word is last in order.
- Assert RST after 2 bytes of a word, then send 4 bytes 0x11,0x22,0x33,0x44 → word 0x44332211; all outputs 0 during reset.
